// File: rtl/secded_decoder_pipe_if.sv
// Handshake and status bundle for the SECDED decoder pipeline.
// The master drives codewords in and consumes results; the slave is the decoder.
interface secded_decoder_pipe_if #(
    parameter int DATA_W = 128,
    parameter int TAG_W  = 8,
    parameter int CNT_W  = 16
);
    function automatic int calc_r(input int dw);
        int r;
        r = 0;
        for (int i = 15; i >= 1; i--) begin
            if ((1 << i) >= dw + i + 1) r = i;
        end
        return r;
    endfunction

    localparam int R = calc_r(DATA_W);
    localparam int N = DATA_W + R + 1;

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      codeword;
    logic [TAG_W-1:0]  in_tag;
    logic              correct_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] message;
    logic [TAG_W-1:0]  out_tag;
    logic              ce;
    logic              ue;
    logic [R-1:0]      err_pos;
    logic              clr_cnt;
    logic [CNT_W-1:0]  ce_cnt;
    logic [CNT_W-1:0]  ue_cnt;
    logic [TAG_W-1:0]  ue_tag_log;
    logic              ue_log_vld;

    modport master (
        output in_valid, codeword, in_tag, correct_en, out_ready, clr_cnt,
        input  in_ready, out_valid, message, out_tag, ce, ue, err_pos,
               ce_cnt, ue_cnt, ue_tag_log, ue_log_vld
    );

    modport slave (
        input  in_valid, codeword, in_tag, correct_en, out_ready, clr_cnt,
        output in_ready, out_valid, message, out_tag, ce, ue, err_pos,
               ce_cnt, ue_cnt, ue_tag_log, ue_log_vld
    );
endinterface

// File: rtl/secded_decoder_pipe.sv
// Two-stage SECDED Hamming decoder: stage 1 registers syndrome/parity, stage 2 corrects,
// extracts data and classifies; saturating CE/UE counters and a first-UE tag log.
module secded_decoder_pipe #(
    parameter int DATA_W = 128,
    parameter int TAG_W  = 8,
    parameter int CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    secded_decoder_pipe_if.slave bus
);
    function automatic int calc_r(input int dw);
        int r;
        r = 0;
        for (int i = 15; i >= 1; i--) begin
            if ((1 << i) >= dw + i + 1) r = i;
        end
        return r;
    endfunction

    localparam int R  = calc_r(DATA_W);
    localparam int N  = DATA_W + R + 1;
    localparam int JW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_out_hs;
    logic [R-1:0]      w_s;
    logic              w_q;
    logic              w_ce;
    logic              w_ue;
    logic [N-1:0]      w_fix;
    logic [DATA_W-1:0] w_msg;

    logic              r_s1_valid;
    logic [N-1:0]      r_s1_cw;
    logic [TAG_W-1:0]  r_s1_tag;
    logic              r_s1_en;
    logic [R-1:0]      r_s1_s;
    logic              r_s1_q;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_msg;
    logic [TAG_W-1:0]  r_out_tag;
    logic              r_ce;
    logic              r_ue;
    logic [R-1:0]      r_err_pos;

    logic [CNT_W-1:0]  r_ce_cnt;
    logic [CNT_W-1:0]  r_ue_cnt;
    logic [TAG_W-1:0]  r_ue_tag_log;
    logic              r_ue_log_vld;

    assign w_s2_adv = ~r_s2_valid | bus.out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign w_out_hs = r_s2_valid & bus.out_ready;

    always_comb begin
        w_s = '0;
        for (int p = 1; p < N; p++) begin
            if (bus.codeword[p-1]) w_s = w_s ^ R'(p);
        end
        w_q = ^bus.codeword;
    end

    always_comb begin : p_decode
        logic [JW-1:0] j;
        w_ce  = 1'b0;
        w_ue  = 1'b0;
        w_fix = r_s1_cw;
        w_msg = '0;
        j     = '0;
        if (r_s1_q) begin
            if (int'(r_s1_s) <= N - 1) w_ce = 1'b1;
            else                       w_ue = 1'b1;
        end else if (r_s1_s != '0) begin
            w_ue = 1'b1;
        end
        // s=0 with q=1 means the overall-parity bit flipped; data needs no repair.
        if (w_ce && (r_s1_s != '0) && r_s1_en) begin
            for (int p = 1; p < N; p++) begin
                if (r_s1_s == R'(p)) w_fix[p-1] = ~w_fix[p-1];
            end
        end
        for (int p = 1; p < N; p++) begin
            if ((p & (p - 1)) != 0) begin
                w_msg[j] = w_fix[p-1];
                j        = j + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_tag   <= '0;
            r_s1_en    <= 1'b0;
            r_s1_s     <= '0;
            r_s1_q     <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_cw  <= bus.codeword;
                r_s1_tag <= bus.in_tag;
                r_s1_en  <= bus.correct_en;
                r_s1_s   <= w_s;
                r_s1_q   <= w_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_msg      <= '0;
            r_out_tag  <= '0;
            r_ce       <= 1'b0;
            r_ue       <= 1'b0;
            r_err_pos  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_msg     <= w_msg;
                r_out_tag <= r_s1_tag;
                r_ce      <= w_ce;
                r_ue      <= w_ue;
                r_err_pos <= w_ce ? r_s1_s : '0;
            end
        end
    end

    // Clear wins over a same-cycle increment or log capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ce_cnt     <= '0;
            r_ue_cnt     <= '0;
            r_ue_tag_log <= '0;
            r_ue_log_vld <= 1'b0;
        end else if (bus.clr_cnt) begin
            r_ce_cnt     <= '0;
            r_ue_cnt     <= '0;
            r_ue_tag_log <= '0;
            r_ue_log_vld <= 1'b0;
        end else if (w_out_hs) begin
            if (r_ce && (r_ce_cnt != '1)) r_ce_cnt <= r_ce_cnt + 1'b1;
            if (r_ue && (r_ue_cnt != '1)) r_ue_cnt <= r_ue_cnt + 1'b1;
            if (r_ue && !r_ue_log_vld) begin
                r_ue_tag_log <= r_out_tag;
                r_ue_log_vld <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_s1_adv;
    assign bus.out_valid  = r_s2_valid;
    assign bus.message    = r_msg;
    assign bus.out_tag    = r_out_tag;
    assign bus.ce         = r_ce;
    assign bus.ue         = r_ue;
    assign bus.err_pos    = r_err_pos;
    assign bus.ce_cnt     = r_ce_cnt;
    assign bus.ue_cnt     = r_ue_cnt;
    assign bus.ue_tag_log = r_ue_tag_log;
    assign bus.ue_log_vld = r_ue_log_vld;
endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Self-checking bench for secded_decoder_pipe: table vectors, random backpressure traffic,
// stall/saturation/clear/reset sequences, with a scoreboard and a counter/log model.
module tb_secded_decoder_pipe;
    localparam int DW = 128;
    localparam int TW = 8;
    localparam int CW = 2;
    localparam int NB = 137;

    typedef struct {
        logic [DW-1:0] msg;
        logic [TW-1:0] tag;
        logic          ce;
        logic          ue;
        logic [7:0]    pos;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          en;
        int            p0;
        int            p1;
        int            p2;
        logic [DW-1:0] msg;
        logic          ce;
        logic          ue;
        logic [7:0]    pos;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    secded_decoder_pipe_if #(.DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) bus ();

    secded_decoder_pipe #(.DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Data bit d sits at position p with d = p - 1 - ceil(log2(p+1)).
    function automatic logic [NB-1:0] enc(input logic [DW-1:0] d);
        logic [NB-1:0] cw;
        logic          par;
        cw = '0;
        for (int p = 1; p < NB; p++) begin
            if ((p & (p - 1)) != 0) cw[p-1] = d[p-1-$clog2(p+1)];
        end
        for (int i = 0; i < 8; i++) begin
            par = 1'b0;
            for (int p = 1; p < NB; p++) begin
                if ((p & (1 << i)) != 0) par = par ^ cw[p-1];
            end
            cw[(1 << i) - 1] = par;
        end
        cw[NB-1] = ^cw[NB-2:0];
        return cw;
    endfunction

    function automatic logic [NB-1:0] flip(input logic [NB-1:0] cw, input int p);
        logic [NB-1:0] r;
        r = cw;
        if (p > 0) r[p-1] = ~r[p-1];
        return r;
    endfunction

    task automatic send(input logic [NB-1:0] cw, input logic [TW-1:0] tag, input logic en,
                        input exp_t e);
        logic acc;
        int   n;
        bus.codeword   = cw;
        bus.in_tag     = tag;
        bus.correct_en = en;
        bus.in_valid   = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            n++;
        end
        chk("accept", acc, 1'b1);
        if (acc) sb.push_back(e);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain_left", sb.size(), 0);
    endtask

    // Scoreboard, output-hold checker and counter/log model, all sampled on negedge.
    logic [CW-1:0] m_ce;
    logic [CW-1:0] m_ue;
    logic [TW-1:0] m_log;
    logic          m_vld;
    logic          p_stall;
    logic [DW-1:0] p_msg;
    logic [17:0]   p_side;
    logic          hs;
    logic          got;
    exp_t          me;

    always @(negedge clk) begin
        if (rst) begin
            m_ce = '0;
            m_ue = '0;
            m_vld = 1'b0;
            m_log = '0;
            p_stall = 1'b0;
            chk("rst_out_valid", bus.out_valid, 1'b0);
        end else begin
            chk("ce_cnt", bus.ce_cnt, m_ce);
            chk("ue_cnt", bus.ue_cnt, m_ue);
            chk("ue_log_vld", bus.ue_log_vld, m_vld);
            if (m_vld) chk("ue_tag_log", bus.ue_tag_log, m_log);
            if (p_stall) begin
                chk("hold_valid", bus.out_valid, 1'b1);
                chk("hold_msg", bus.message, p_msg);
                chk("hold_side", {bus.out_tag, bus.ce, bus.ue, bus.err_pos}, p_side);
            end
            hs  = bus.out_valid && bus.out_ready;
            got = 1'b0;
            if (hs) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", bus.out_valid, 1'b0);
                end else begin
                    me  = sb.pop_front();
                    got = 1'b1;
                    chk("message", bus.message, me.msg);
                    chk("out_tag", bus.out_tag, me.tag);
                    chk("ce", bus.ce, me.ce);
                    chk("ue", bus.ue, me.ue);
                    chk("err_pos", bus.err_pos, me.pos);
                end
            end
            if (bus.clr_cnt) begin
                m_ce  = '0;
                m_ue  = '0;
                m_vld = 1'b0;
            end else if (got) begin
                if (me.ce && m_ce != '1) m_ce = m_ce + 1'b1;
                if (me.ue && m_ue != '1) m_ue = m_ue + 1'b1;
                if (me.ue && !m_vld) begin
                    m_vld = 1'b1;
                    m_log = me.tag;
                end
            end
            p_stall = bus.out_valid && !bus.out_ready;
            p_msg   = bus.message;
            p_side  = {bus.out_tag, bus.ce, bus.ue, bus.err_pos};
        end
    end

    localparam logic [DW-1:0] D1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [DW-1:0] D0 = '0;
    localparam logic [DW-1:0] DF = '1;

    vec_t          vt[12];
    exp_t          e;
    logic [NB-1:0] cw;
    logic [DW-1:0] rd;
    int            rp;
    int            n;
    logic [CW-1:0] sat_seq[5];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.codeword = '0;
        bus.in_tag = '0;
        bus.correct_en = 1'b1;
        bus.out_ready = 1'b1;
        bus.clr_cnt = 1'b0;

        vt[0]  = '{D0, 8'h11, 1'b1, 0, 0, 0, D0, 1'b0, 1'b0, 8'd0};
        vt[1]  = '{D0, 8'h21, 1'b1, 3, 0, 0, D0, 1'b1, 1'b0, 8'd3};
        vt[2]  = '{D0, 8'h22, 1'b0, 3, 0, 0, 128'h1, 1'b1, 1'b0, 8'd3};
        vt[3]  = '{D0, 8'h23, 1'b1, 3, 5, 0, 128'h3, 1'b0, 1'b1, 8'd0};
        vt[4]  = '{D1, 8'h24, 1'b1, 137, 0, 0, D1, 1'b1, 1'b0, 8'd0};
        vt[5]  = '{D1, 8'h25, 1'b0, 1, 0, 0, D1, 1'b1, 1'b0, 8'd1};
        vt[6]  = '{D1, 8'h26, 1'b1, 136, 0, 0, D1, 1'b1, 1'b0, 8'd136};
        vt[7]  = '{D1, 8'h27, 1'b0, 136, 0, 0, D1 ^ (128'd1 << 127), 1'b1, 1'b0, 8'd136};
        vt[8]  = '{D1, 8'h28, 1'b1, 128, 64, 63, D1 ^ (128'd1 << 56), 1'b0, 1'b1, 8'd0};
        vt[9]  = '{D1, 8'h29, 1'b1, 137, 10, 0, D1 ^ (128'd1 << 5), 1'b0, 1'b1, 8'd0};
        vt[10] = '{DF, 8'h2a, 1'b1, 0, 0, 0, DF, 1'b0, 1'b0, 8'd0};
        vt[11] = '{D1, 8'h2b, 1'b1, 100, 0, 0, D1, 1'b1, 1'b0, 8'd100};
        sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_message", bus.message, '0);
        chk("rst_flags", {bus.ce, bus.ue, bus.err_pos, bus.out_tag}, '0);
        chk("rst_cnts", {bus.ce_cnt, bus.ue_cnt, bus.ue_log_vld, bus.ue_tag_log}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Latency: valid appears after the second edge
        e = '{D0, 8'h11, 1'b0, 1'b0, 8'd0};
        send(enc(D0), 8'h11, 1'b1, e);
        chk("lat_1cyc_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1 chk("lat_2cyc_valid", bus.out_valid, 1'b1);
        drain();

        // Table vectors, back to back
        for (int i = 0; i < 12; i++) begin
            cw = flip(flip(flip(enc(vt[i].data), vt[i].p0), vt[i].p1), vt[i].p2);
            e  = '{vt[i].msg, vt[i].tag, vt[i].ce, vt[i].ue, vt[i].pos};
            send(cw, vt[i].tag, vt[i].en, e);
        end
        drain();

        // Random single errors under random backpressure
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    rd = {$urandom, $urandom, $urandom, $urandom};
                    rp = int'($urandom_range(1, NB));
                    e  = '{rd, 8'(i + 8'h40), 1'b1, 1'b0, (rp == NB) ? 8'd0 : 8'(rp)};
                    send(flip(enc(rd), rp), 8'(i + 8'h40), 1'b1, e);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Stall: two accepted, third blocked, all three drain in order
        bus.out_ready = 1'b0;
        fork
            begin
                e = '{D1, 8'h51, 1'b0, 1'b0, 8'd0};
                send(enc(D1), 8'h51, 1'b1, e);
                e = '{DF, 8'h52, 1'b1, 1'b0, 8'd7};
                send(flip(enc(DF), 7), 8'h52, 1'b1, e);
                e = '{D0, 8'h53, 1'b0, 1'b0, 8'd0};
                send(enc(D0), 8'h53, 1'b1, e);
            end
            begin
                repeat (3) @(negedge clk);
                chk("stall_in_ready", bus.in_ready, 1'b0);
                chk("stall_out_valid", bus.out_valid, 1'b1);
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // CE saturation with CNT_W=2, then clear coincident with a CE handshake
        bus.clr_cnt = 1'b1;
        @(posedge clk);
        #1 bus.clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            e = '{D0, 8'(8'h60 + i), 1'b1, 1'b0, 8'd3};
            send(flip(enc(D0), 3), 8'(8'h60 + i), 1'b1, e);
            drain();
            chk("ce_sat_seq", bus.ce_cnt, sat_seq[i]);
        end
        bus.out_ready = 1'b0;
        e = '{D0, 8'h66, 1'b1, 1'b0, 8'd3};
        send(flip(enc(D0), 3), 8'h66, 1'b1, e);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        chk("clr_wait_valid", bus.out_valid, 1'b1);
        bus.clr_cnt   = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.clr_cnt = 1'b0;
        chk("clr_vs_inc", bus.ce_cnt, '0);
        drain();

        // Reset with both stages full
        e = '{128'h3, 8'h70, 1'b0, 1'b1, 8'd0};
        send(flip(flip(enc(D0), 3), 5), 8'h70, 1'b1, e);
        drain();
        chk("ue_cnt_pre_rst", bus.ue_cnt, 2'd1);
        bus.out_ready = 1'b0;
        e = '{D1, 8'h71, 1'b0, 1'b0, 8'd0};
        send(enc(D1), 8'h71, 1'b1, e);
        e = '{D1, 8'h72, 1'b0, 1'b0, 8'd0};
        send(enc(D1), 8'h72, 1'b1, e);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_cnts", {bus.ce_cnt, bus.ue_cnt, bus.ue_log_vld}, '0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_word", bus.out_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/secded_decoder_pipe.md
SECDED_DECODER_PIPE -- requirements
Module: secded_decoder_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 128, message width in bits (legal range 8..247).
REQ-002 SHALL have parameter TAG_W, default 8, sideband tag width carried alongside each word.
REQ-003 SHALL have parameter CNT_W, default 16, width of each error counter.
REQ-004 SHALL derive localparam R = smallest r with 2^r >= DATA_W+r+1 (R=8 at default), and N = DATA_W+R+1 (137 at default).
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk, input, 1, rising-edge clock; rst, input, 1, reset.
REQ-006 SHALL have in_valid, input, 1, codeword presented.
REQ-007 SHALL have in_ready, output, 1, codeword accepted when in_valid&in_ready.
REQ-008 SHALL have codeword, input, N, received SECDED word.
REQ-009 SHALL have in_tag, input, TAG_W, sideband carried unchanged.
REQ-010 SHALL have correct_en, input, 1, 1=correct single errors, 0=detect only; sampled with the word.
REQ-011 SHALL have out_valid, output, 1, result valid.
REQ-012 SHALL have out_ready, input, 1, result consumed when out_valid&out_ready.
REQ-013 SHALL have message, output, DATA_W, decoded data.
REQ-014 SHALL have out_tag, output, TAG_W, tag of this result.
REQ-015 SHALL have ce, output, 1, single error detected; ue, output, 1, uncorrectable error detected.
REQ-016 SHALL have err_pos, output, R, Hamming position of the single error (0 if none or overall-parity bit).
REQ-017 SHALL have clr_cnt, input, 1, synchronous counter clear.
REQ-018 SHALL have ce_cnt and ue_cnt, output, CNT_W each, saturating error counts.
REQ-019 SHALL have ue_tag_log, output, TAG_W, tag of first UE since reset or clr_cnt; ue_log_vld, output, 1, log holds a tag.

Function
REQ-020 SHALL map codeword[p-1] to Hamming position p (1..N-1); powers of two are check bits; data bits fill remaining positions ascending, message[0] at lowest; codeword[N-1] is overall even parity over all N bits.
REQ-021 SHALL compute syndrome s (R bits) = XOR of positions p whose bit is 1, and overall parity q = XOR of all N bits.
REQ-022 SHALL classify: s=0,q=0 none; q=1,s=0 single error in overall bit (ce=1, err_pos=0); q=1, 1<=s<=N-1 single error at s (ce=1, err_pos=s); q=1, s>N-1 ue=1; s!=0,q=0 ue=1.
REQ-023 SHALL flip position s before data extraction only when ce=1, s!=0, and correct_en=1; otherwise message is raw data bits; ce/err_pos reported regardless of correct_en.
REQ-024 SHALL be a 2-stage pipeline: stage 1 registers codeword, tag, correct_en, s, q; stage 2 registers message, flags, err_pos, tag.
REQ-025 SHALL give latency of exactly 2 cycles from accepting edge to out_valid when out_ready stays high; throughput 1 word/cycle.
REQ-026 SHALL advance stage 2 when ~s2_valid|out_ready, stage 1 when ~s1_valid|stage-2 advance; in_ready = ~s1_valid|stage-2 advance (combinational from out_ready).
REQ-027 SHALL hold all outputs stable while out_valid&~out_ready; no word dropped, duplicated or reordered.
REQ-028 SHALL update counters on output handshake: ce_cnt+=ce, ue_cnt+=ue, each saturating at 2^CNT_W-1.
REQ-029 SHALL give clr_cnt priority over a same-cycle increment or log capture: counters go 0, ue_log_vld goes 0.
REQ-030 SHALL capture out_tag into ue_tag_log and set ue_log_vld on first UE handshake while ue_log_vld=0; later UEs do not overwrite.

Reset
REQ-031 SHALL on rst asynchronously clear s1_valid, s2_valid, out_valid, ce, ue, err_pos, message, out_tag, counters, ue_tag_log, ue_log_vld to 0; in_ready is 1 the first cycle after rst falls.
REQ-032 SHALL discard in-flight words when rst asserts mid-operation; none emerge after release.

Verification
REQ-033 All-zero codeword, tag 0x11, out_ready=1 -> out_valid 2 cycles later, message=0, ce=ue=0, out_tag=0x11.
REQ-034 All-zero codeword with codeword[2] set (position 3, message[0]) -> message=0, ce=1, err_pos=3, ce_cnt=1; same with correct_en=0 -> message=0x1, ce=1.
REQ-035 All-zero codeword with codeword[2] and codeword[4] set -> ue=1, ce=0, message=0x3, ue_cnt=1, ue_tag_log=that tag, ue_log_vld=1.
REQ-036 Three back-to-back words with out_ready=0 for 5 cycles -> in_ready low after 2 accepted; on out_ready=1 all 3 emerge in order, unchanged.
REQ-037 CNT_W=2, five CE words -> ce_cnt 1,2,3,3,3; clr_cnt coincident with a CE handshake -> ce_cnt=0.
REQ-038 rst pulsed with both stages full -> out_valid=0 immediately, counters 0, no stale word after release.
